// File: rtl/riscv_pkg.sv
// Shared RV32 constants and types used by the fetch and decode stages.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef logic [XLEN-1:0] instr_t;

    typedef struct packed {
        instr_t          instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer FIFO for fetched {instruction, pc} pairs; flush empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order memory requests, response buffering, redirect/flush.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instruction,
    output logic [XLEN-1:0] id_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_use;
    logic            accept;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign target         = redirect_pc & ~XLEN'(3);
    assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && !redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign pop            = id_valid && id_ready;
    assign push_entry     = '{instr: imem_rsp_data, pc: rsp_pc};

    assign id_valid       = !fifo_empty;
    assign id_instruction = fifo_empty ? INSTR_NOP : head_entry.instr;
    assign id_pc          = fifo_empty ? '0 : head_entry.pc;

    // rsp_pc is the PC of the next kept response: requests are sequential between
    // redirects, so a counter reloaded on redirect replaces a per-request tag queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc       <= target;
                rsp_pc   <= target;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (accept) pc <= pc + XLEN'(4);
                if (imem_rsp_valid) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                    else                rsp_pc   <= rsp_pc + XLEN'(4);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .pop_data  (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the combinational decoder. It holds the PC and issues in-order word requests to instruction memory over a valid/ready handshake. Responses are buffered with their PC in a small FIFO, and {instruction, pc} is presented to the decode stage with a valid/ready handshake. The stage supports redirect (branch/jump) with flush and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, FIFO entries; also the maximum of outstanding plus buffered requests (power of 2, ≥2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word address of request (bits[1:0] always 0)
imem_rsp_valid  in  1  response valid; one per accepted request, in order, ≥1 cycle after acceptance, never back-pressured
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  control-flow redirect, single-cycle pulse
redirect_pc  in  32  redirect target
id_valid  out  1  instruction available to decode
id_ready  in  1  decode consumes instruction
id_instruction  out  32  instruction to decoder (NOP 32'h0000_0013 when id_valid=0)
id_pc  out  32  PC of id_instruction (0 when id_valid=0)

Behaviour:
- Reset is asynchronous and active-high, with the clock named clk and the reset named rst. On reset: pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, id_valid=0, id_instruction=32'h13, id_pc=0, imem_req_valid=0 (only during reset assertion).
- Credit rule: imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count < DEPTH). A same-cycle pop does not free a credit.
- imem_req_addr = pc. Request accepted when valid && ready. On acceptance: pc += 4 and outstanding++.
- While imem_req_valid=1 and ready=0, addr holds stable.
- On response: outstanding--. If drop_cnt>0, drop_cnt-- and data is discarded. Otherwise {pc_of_request, data} is pushed. Request PCs travel in a tag queue, or are derived from a fetch-order PC counter; either way id_pc is exact.
- Latency: a request accepted at cycle N with response at N+1 gives id_valid at N+2 (registered FIFO output). Data is not bypassed.
- Pop when id_valid && id_ready. id_instruction/id_pc reflect the FIFO head.
- Push and pop in the same cycle with FIFO full is legal only because the credit rule prevents overflow. A push into a full FIFO is an assertion error.
- Redirect (redirect_valid=1):
  - pc <= {redirect_pc[31:2], 2'b00}, so misaligned targets are truncated.
  - FIFO flushed next cycle and id_valid=0.
  - drop_cnt <= outstanding − (rsp_valid this cycle ? 1 : 0).
  - No request is issued in the redirect cycle.
  - A response arriving in the redirect cycle is dropped.
  - An id handshake in the redirect cycle is allowed; that entry counts as consumed.
- Back-to-back redirects: the last one wins, and drop_cnt is recomputed from the current outstanding each time.
- Wrap-around: pc 32'hFFFF_FFFC + 4 = 0, with no error.
- Counters: outstanding and fifo_count are clog2(DEPTH)+1 bits wide, saturating never required.
- Reset mid-operation: all state cleared immediately. Responses to pre-reset requests are the memory's responsibility and are not tracked.

Decomposition:
- Shared package riscv_pkg: XLEN=32, INSTR_NOP=32'h0000_0013, DEFAULT_RESET_PC, and an instruction-word typedef shared with the decoder.
- Sub-module fetch_fifo: parameterised DEPTH×64-bit synchronous FIFO with push, pop, flush, count, empty and full. The same async active-high reset applies.

Test Plan:
1. Reset, then memory ready with 1-cycle responses 33, 00108093, 13, 00112023, 63 -> addrs 0,4,8,C,10 in order; id_pc 0,4,8,C,10 with matching instructions; first id_valid 2 cycles after first accept.
2. id_ready=0 for 10 cycles -> exactly 2 requests accepted; then imem_req_valid=0; id_instruction holds 32'h33 at pc 0; after release the stream resumes with no loss or duplication.
3. With 2 requests outstanding, redirect to 32'h100 -> both responses dropped; next request addr 0x100; first id_pc=0x100.
4. Redirect to 32'h102 in the same cycle as a response and an id handshake -> fetch addr 0x100; the response is dropped; no stale id_valid afterwards.
5. Set pc to 32'hFFFF_FFF8 via redirect and run 3 fetches -> addrs FFFF_FFF8, FFFF_FFFC, 0000_0000.
6. Assert rst asynchronously mid-stream (between clock edges) -> outputs immediately reset values; after release the first addr is RESET_PC.
